// File: rtl/axi_stream_custom_ip_pkg.sv
// Shared definitions for the sample-to-AXI4-Stream buffer.
//   clog2 : ceiling log2, used to size addresses, pointers and counters
//   PTR_W : pointer width for the default depth (address bits plus wrap bit)
package axi_stream_custom_ip_pkg;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    localparam int DEFAULT_DEPTH = 1024;
    localparam int PTR_W         = clog2(DEFAULT_DEPTH) + 1;

endpackage

// File: rtl/axi_stream_custom_ip_if.sv
// AXI4-Stream beat bundle.
//   tvalid/tdata/tstrb/tlast : driven by the master
//   tready                   : driven by the slave
interface axi_stream_custom_ip_if #(
    parameter int WIDTH = 32
);
    logic               tvalid;
    logic               tready;
    logic [WIDTH-1:0]   tdata;
    logic [WIDTH/8-1:0] tstrb;
    logic               tlast;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axi_stream_custom_ip_sp_fifo_ram.sv
// Simple dual-port RAM, WIDTH x DEPTH, for the stream buffer.
//   wr_clk      : clock for both ports
//   rst_n       : async active-low reset, clears only the read register
//   we/waddr/wdata : write port
//   re/raddr    : read enable and address
//   rdata       : registered read data; holds its value while re is low
// A read and a write to the same address on the same edge return the old word.
module sp_fifo_ram
    import axi_stream_custom_ip_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                    wr_clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    re,
    input  logic [clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wr_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/axi_stream_custom_ip.sv
// Buffer from a valid-only sample source into an AXI4-Stream master.
//   m00_axis_aclk    : single clock
//   m00_axis_aresetn : async active-low reset, release synchronised internally
//   din_valid/din    : sample strobe and data, no backpressure
//   fifo_full        : memory full; samples offered now are dropped unless a
//                      read frees a slot on the same edge
//   m00_axis         : AXI4-Stream master; tlast every PKT_LEN-th beat
// The RAM read register is the output stage, so capacity is DEPTH+1 words.
module axi_stream_custom_ip
    import axi_stream_custom_ip_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 1024,
    parameter int PKT_LEN = DEPTH
) (
    input  logic                   m00_axis_aclk,
    input  logic                   m00_axis_aresetn,
    input  logic                   din_valid,
    input  logic [WIDTH-1:0]       din,
    output logic                   fifo_full,
    axi_stream_custom_ip_if.master m00_axis
);
    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (PKT_LEN > 1) ? clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

    logic [1:0]    rst_sync;
    logic          rst_int_n;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] beat_cnt;
    logic          tvalid_q;
    logic          mem_empty;
    logic          mem_full;
    logic          rd_en;
    logic          wr_en;
    logic          handshake;

    // Assert immediately, release two edges after aresetn rises.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync[1];

    assign mem_empty = (wr_ptr == rd_ptr);
    assign mem_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign handshake = tvalid_q && m00_axis.tready;
    assign rd_en     = !mem_empty && (!tvalid_q || m00_axis.tready);
    // A read on this edge frees the slot the write lands in.
    assign wr_en     = din_valid && (!mem_full || rd_en);

    always_ff @(posedge m00_axis_aclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tvalid_q <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr   <= rd_ptr + PW'(1);
                tvalid_q <= 1'b1;
            end else if (handshake) begin
                tvalid_q <= 1'b0;
            end
            if (handshake) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
            end
        end
    end

    sp_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .wr_clk (m00_axis_aclk),
        .rst_n  (rst_int_n),
        .we     (wr_en),
        .waddr  (wr_ptr[AW-1:0]),
        .wdata  (din),
        .re     (rd_en),
        .raddr  (rd_ptr[AW-1:0]),
        .rdata  (m00_axis.tdata)
    );

    assign fifo_full       = mem_full;
    assign m00_axis.tvalid = tvalid_q;
    assign m00_axis.tlast  = tvalid_q && (beat_cnt == LAST_BEAT);
    assign m00_axis.tstrb  = '1;
endmodule

// File: tb/tb_axi_stream_custom_ip.sv
module tb_axi_stream_custom_ip;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 1024;
    localparam int PKT_LEN = DEPTH;

    logic             clk = 1'b0;
    logic             aresetn = 1'b0;
    logic             din_valid = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             fifo_full;

    axi_stream_custom_ip_if #(.WIDTH(WIDTH)) axis ();

    axi_stream_custom_ip #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (aresetn),
        .din_valid        (din_valid),
        .din              (din),
        .fifo_full        (fifo_full),
        .m00_axis         (axis)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_beats = 0;
    logic [WIDTH-1:0] exp_q[$];

    // Reference model: words in memory and whether the output stage holds a word.
    int mem_cnt = 0;
    bit out_v = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every handshake against the scoreboard queue.
    initial begin
        int beat;
        bit stall;
        logic [WIDTH-1:0] prev_data;
        logic prev_last;
        beat = 0;
        stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                beat = 0;
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_tvalid", axis.tvalid, 1);
                    check("hold_tdata", axis.tdata, prev_data);
                    check("hold_tlast", axis.tlast, prev_last);
                end
                if (axis.tvalid) begin
                    check("tlast", axis.tlast, (beat == PKT_LEN - 1));
                    if (axis.tready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_beat", axis.tdata, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            check("tdata", axis.tdata, exp_q.pop_front());
                        end
                        beat = (beat + 1) % PKT_LEN;
                        n_beats++;
                    end
                end else begin
                    check("tlast_idle", axis.tlast, 0);
                end
                stall = axis.tvalid && !axis.tready;
                prev_data = axis.tdata;
                prev_last = axis.tlast;
            end
        end
    end

    // One clock of stimulus; predicts acceptance and the state after the next edge.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit rdy);
        bit rd;
        bit acc;
        bit hs;
        @(posedge clk);
        #1;
        check("tvalid", axis.tvalid, out_v);
        check("fifo_full", fifo_full, (mem_cnt == DEPTH));
        din_valid = v;
        din = d;
        axis.tready = rdy;
        rd  = (mem_cnt > 0) && (!out_v || rdy);
        acc = v && ((mem_cnt < DEPTH) || rd);
        hs  = out_v && rdy;
        if (acc) exp_q.push_back(d);
        mem_cnt = mem_cnt + int'(acc) - int'(rd);
        if (rd) out_v = 1'b1;
        else if (hs) out_v = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        aresetn = 1'b0;
        din_valid = 1'b0;
        #1;
        check("rst_tvalid_now", axis.tvalid, 0);
        exp_q.delete();
        mem_cnt = 0;
        out_v = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tlast", axis.tlast, 0);
        check("rst_full", fifo_full, 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_tstrb", axis.tstrb, 4'hF);
        aresetn = 1'b1;
        repeat (4) step(1'b0, '0, 1'b0);
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) step(1'b0, '0, 1'b1);
    endtask

    initial begin
        int base;
        int words;
        axis.tready = 1'b0;

        // 1: reset values
        do_reset(10);

        // 2: 1024 words streamed straight through, one packet
        base = n_beats;
        for (int i = 0; i < 1024; i++) step(1'b1, WIDTH'(32'h1000 + i), 1'b1);
        drain(8);
        check("t2_beats", n_beats - base, 1024);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: overfill with tready low, then drain
        do_reset(3);
        base = n_beats;
        for (int i = 0; i < 1030; i++) step(1'b1, WIDTH'(32'h1000 + i), 1'b0);
        @(negedge clk);
        check("t3_full", fifo_full, 1);
        check("t3_tdata_first", axis.tdata, 32'h1000);
        drain(1100);
        check("t3_beats", n_beats - base, 1025);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: concurrent writes and reads with random tready
        do_reset(3);
        base = n_beats;
        words = 0;
        for (int i = 0; i < 3000; i++) begin
            bit v;
            v = ($urandom_range(0, 9) < 6);
            if (v) words++;
            step(v, WIDTH'(32'h1000 - i), bit'($urandom_range(0, 1)));
        end
        drain(1100);
        check("t4_queue_empty", exp_q.size(), 0);
        check("t4_beats_le_written", (n_beats - base) <= words, 1);

        // 5: latency of a single word, then a mid-stream reset
        do_reset(3);
        step(1'b1, 32'hABCD_0001, 1'b0);
        step(1'b0, '0, 1'b0);
        check("t5_latency_k", axis.tvalid, 0);
        step(1'b0, '0, 1'b0);
        check("t5_latency_k1", axis.tvalid, 1);
        check("t5_latency_data", axis.tdata, 32'hABCD_0001);
        for (int i = 0; i < 40; i++) step(1'b1, WIDTH'(32'h2000 + i), bit'($urandom_range(0, 1)));
        do_reset(2);
        base = n_beats;
        for (int i = 0; i < 20; i++) step(1'b1, WIDTH'(32'h5555_0000 + i), bit'($urandom_range(0, 1)));
        drain(30);
        check("t5_post_reset_beats", n_beats - base, 20);
        check("t5_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
